// File: rtl/cache_pkg.sv
// Shared types, widths and address helpers for the cache line fill unit.
package cache_pkg;

  localparam int ADDR_W     = 32;
  localparam int INDEX_W    = 10;
  localparam int TAG_W      = 18;
  localparam int OFFSET_W   = 4;
  localparam int BEAT_W     = 32;
  localparam int LINE_W     = 128;
  localparam int BEATS      = 4;
  localparam int BEAT_IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    RD     = 2'd2,
    COMMIT = 2'd3
  } fill_state_t;

  typedef struct packed {
    logic [TAG_W-1:0]      tag;
    logic [INDEX_W-1:0]    index;
    logic [BEAT_IDX_W-1:0] word;
    logic                  dirty;
    logic [TAG_W-1:0]      evict_tag;
    logic [LINE_W-1:0]     evict_line;
  } fill_ctx_t;

  // Byte address layout: {tag, index, word[1:0], byte[1:0]}
  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [BEAT_IDX_W-1:0] addr_word(input logic [ADDR_W-1:0] addr);
    return addr[2 +: BEAT_IDX_W];
  endfunction

  function automatic logic [ADDR_W-1:0] beat_addr(input logic [TAG_W-1:0]      tag,
                                                  input logic [INDEX_W-1:0]    index,
                                                  input logic [BEAT_IDX_W-1:0] beat);
    return {tag, index, beat, 2'b00};
  endfunction

endpackage

// File: rtl/cache_line_fill_unit_if.sv
// Request, RAM beat and cache write bundle of the cache line fill unit.
// master = the fill unit, slave = requester / RAM / cache environment.
interface cache_line_fill_unit_if;
  import cache_pkg::*;

  logic                  fill_req;
  logic                  fill_ready;
  logic [ADDR_W-1:0]     fill_addr;
  logic                  evict_dirty;
  logic [TAG_W-1:0]      evict_tag;
  logic [LINE_W-1:0]     evict_line;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [BEAT_W-1:0]     mem_wdata;
  logic [BEAT_W-1:0]     mem_rdata;
  logic                  mem_ack;
  logic                  cache_wrEn;
  logic [INDEX_W-1:0]    cache_index;
  logic [LINE_W-1:0]     cache_line;
  logic                  fill_done;
  logic                  crit_valid;
  logic [BEAT_W-1:0]     crit_word;

  modport master (
    input  fill_req, fill_addr, evict_dirty, evict_tag, evict_line, mem_rdata, mem_ack,
    output fill_ready, mem_req, mem_we, mem_addr, mem_wdata,
           cache_wrEn, cache_index, cache_line, fill_done, crit_valid, crit_word
  );

  modport slave (
    output fill_req, fill_addr, evict_dirty, evict_tag, evict_line, mem_rdata, mem_ack,
    input  fill_ready, mem_req, mem_we, mem_addr, mem_wdata,
           cache_wrEn, cache_index, cache_line, fill_done, crit_valid, crit_word
  );

endinterface

// File: rtl/cache_line_buffer.sv
// Four-slot beat buffer that assembles one cache line; clear wins over write.
module cache_line_buffer
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [BEAT_IDX_W-1:0] wr_slot,
  input  logic [BEAT_W-1:0]     wr_data,
  output logic [LINE_W-1:0]     line
);

  logic [BEATS-1:0][BEAT_W-1:0] slot_q;
  logic [BEATS-1:0][BEAT_W-1:0] slot_d;

  // Slot update: slot n holds word n of the line
  always_comb begin
    slot_d = slot_q;
    if (clr) begin
      slot_d = '0;
    end else if (wr_en) begin
      slot_d[wr_slot] = wr_data;
    end else begin
      slot_d = slot_q;
    end
  end

  // Slot storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign line = slot_q;

endmodule

// File: rtl/cache_line_fill_unit.sv
// Miss-service engine: optional dirty-victim write-back, 4-beat line read, one cache write.
// Optional macro CACHE_CRITICAL_WORD_FIRST_EN: read beats start at the missed word.
module cache_line_fill_unit
  import cache_pkg::*;
(
  input  logic                   globalclock,
  input  logic                   reset,
  cache_line_fill_unit_if.master bus
);

  fill_state_t           state_q, state_d;
  logic [BEAT_IDX_W-1:0] beat_q, beat_d;
  logic                  pending_q, pending_d;
  fill_ctx_t             ctx_q, ctx_d;

  logic                  fill_ready_s, accept_s, ack_s, buf_clr_s, buf_wr_s;
  logic [BEAT_IDX_W-1:0] rd_start_s, beat_inc_s;
  logic [LINE_W-1:0]     buf_line_s;
  logic                  mem_req_s, mem_we_s, cache_wren_s, fill_done_s;
  logic [ADDR_W-1:0]     mem_addr_s;
  logic [BEAT_W-1:0]     mem_wdata_s;
  logic [INDEX_W-1:0]    cache_index_s;
  logic [LINE_W-1:0]     cache_line_s;

  // pending_q covers the cycle between acceptance and the first bus beat
  assign fill_ready_s = (state_q == IDLE) && !pending_q;
  assign accept_s     = bus.fill_req && fill_ready_s;
  assign ack_s        = bus.mem_ack && ((state_q == WB) || (state_q == RD));
  assign beat_inc_s   = beat_q + 2'd1;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  assign rd_start_s = ctx_q.word;
`else
  assign rd_start_s = 2'd0;
`endif

  // Request capture at the acceptance edge
  always_comb begin
    ctx_d = ctx_q;
    if (accept_s) begin
      ctx_d.tag        = addr_tag(bus.fill_addr);
      ctx_d.index      = addr_index(bus.fill_addr);
      ctx_d.word       = addr_word(bus.fill_addr);
      ctx_d.dirty      = bus.evict_dirty;
      ctx_d.evict_tag  = bus.evict_tag;
      ctx_d.evict_line = bus.evict_line;
    end else begin
      ctx_d = ctx_q;
    end
  end

  // Next state, beat counter and buffer control
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    pending_d = pending_q;
    buf_clr_s = 1'b0;
    buf_wr_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          pending_d = 1'b1;
          buf_clr_s = 1'b1;
        end else if (pending_q) begin
          pending_d = 1'b0;
          if (ctx_q.dirty) begin
            state_d = WB;
            beat_d  = 2'd0;
          end else begin
            state_d = RD;
            beat_d  = rd_start_s;
          end
        end else begin
          pending_d = 1'b0;
        end
      end
      WB: begin
        if (ack_s) begin
          if (beat_q == 2'd3) begin
            state_d = RD;
            beat_d  = rd_start_s;
          end else begin
            beat_d = beat_inc_s;
          end
        end else begin
          beat_d = beat_q;
        end
      end
      RD: begin
        if (ack_s) begin
          buf_wr_s = 1'b1;
          beat_d   = beat_inc_s;
          // the read run ends once the counter wraps back to its start word
          if (beat_inc_s == rd_start_s) begin
            state_d = COMMIT;
          end else begin
            state_d = RD;
          end
        end else begin
          beat_d = beat_q;
        end
      end
      COMMIT: begin
        state_d = IDLE;
        beat_d  = 2'd0;
      end
      default: begin
        state_d   = IDLE;
        beat_d    = 2'd0;
        pending_d = 1'b0;
      end
    endcase
  end

  // Control and request-context registers
  always_ff @(posedge globalclock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      beat_q    <= 2'd0;
      pending_q <= 1'b0;
      ctx_q     <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      pending_q <= pending_d;
      ctx_q     <= ctx_d;
    end
  end

  cache_line_buffer u_line_buffer (
    .clk     (globalclock),
    .reset   (reset),
    .clr     (buf_clr_s),
    .wr_en   (buf_wr_s),
    .wr_slot (beat_q),
    .wr_data (bus.mem_rdata),
    .line    (buf_line_s)
  );

  // Moore output decode; data outputs stay zero outside their own state
  always_comb begin
    mem_req_s     = 1'b0;
    mem_we_s      = 1'b0;
    mem_addr_s    = 32'd0;
    mem_wdata_s   = 32'd0;
    cache_wren_s  = 1'b0;
    cache_index_s = 10'd0;
    cache_line_s  = 128'd0;
    fill_done_s   = 1'b0;
    case (state_q)
      IDLE: begin
        mem_req_s = 1'b0;
      end
      WB: begin
        mem_req_s   = 1'b1;
        mem_we_s    = 1'b1;
        mem_addr_s  = beat_addr(ctx_q.evict_tag, ctx_q.index, beat_q);
        mem_wdata_s = ctx_q.evict_line[{beat_q, 5'd0} +: BEAT_W];
      end
      RD: begin
        mem_req_s  = 1'b1;
        mem_addr_s = beat_addr(ctx_q.tag, ctx_q.index, beat_q);
      end
      COMMIT: begin
        cache_wren_s  = 1'b1;
        cache_index_s = ctx_q.index;
        cache_line_s  = buf_line_s;
        fill_done_s   = 1'b1;
      end
      default: begin
        mem_req_s = 1'b0;
      end
    endcase
  end

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  logic              crit_valid_q, crit_valid_d;
  logic [BEAT_W-1:0] crit_word_q, crit_word_d;

  // The first read ack is always the critical word
  always_comb begin
    crit_valid_d = (state_q == RD) && bus.mem_ack && (beat_q == ctx_q.word);
    if (crit_valid_d) begin
      crit_word_d = bus.mem_rdata;
    end else begin
      crit_word_d = 32'd0;
    end
  end

  // Critical-word pulse registers
  always_ff @(posedge globalclock or posedge reset) begin
    if (reset) begin
      crit_valid_q <= 1'b0;
      crit_word_q  <= 32'd0;
    end else begin
      crit_valid_q <= crit_valid_d;
      crit_word_q  <= crit_word_d;
    end
  end

  assign bus.crit_valid = crit_valid_q;
  assign bus.crit_word  = crit_word_q;
`else
  assign bus.crit_valid = 1'b0;
  assign bus.crit_word  = 32'd0;
`endif

  assign bus.fill_ready  = fill_ready_s;
  assign bus.mem_req     = mem_req_s;
  assign bus.mem_we      = mem_we_s;
  assign bus.mem_addr    = mem_addr_s;
  assign bus.mem_wdata   = mem_wdata_s;
  assign bus.cache_wrEn  = cache_wren_s;
  assign bus.cache_index = cache_index_s;
  assign bus.cache_line  = cache_line_s;
  assign bus.fill_done   = fill_done_s;

endmodule

// File: tb/tb_cache_line_fill_unit.sv
// Self-checking bench for cache_line_fill_unit: transaction-level model plus literal pins.
module tb_cache_line_fill_unit;
  import cache_pkg::*;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  localparam bit CRIT = 1'b1;
`else
  localparam bit CRIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  cache_line_fill_unit_if bus();

  cache_line_fill_unit dut (
    .globalclock (clk),
    .reset       (reset),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  acc_t         exp_q[$];
  logic [31:0]  addr_log[$];
  logic [31:0]  wdata_log[$];
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  bit           fill_active = 1'b0;
  int           accept_edge = 0;
  int           exp_commit = 0;
  int           commit_edge = 0;
  int           wait_cycles = 0;
  int           wait_cnt = 0;
  int           accept_count = 0;
  int           done_count = 0;
  int           last_done_neg = -100;
  int           accept_gap = 0;
  int           rd_acks = 0;
  int           crit_cyc = -1;
  logic [31:0]  crit_exp = 32'd0;
  logic [31:0]  got_crit = 32'd0;
  logic [31:0]  ram_base = 32'd0;
  logic [9:0]   exp_index = 10'd0;
  logic [127:0] exp_line = 128'd0;
  logic [127:0] got_line = 128'd0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected RAM traffic and committed line derived from the request on the bus
  task automatic plan_fill();
    acc_t        a;
    logic [17:0] tag;
    logic [9:0]  idx;
    int          start;
    int          w;
    tag   = bus.fill_addr[31:14];
    idx   = bus.fill_addr[13:4];
    start = CRIT ? int'(bus.fill_addr[3:2]) : 0;
    exp_q.delete();
    if (bus.evict_dirty) begin
      for (int i = 0; i < 4; i++) begin
        a.we    = 1'b1;
        a.addr  = (32'(bus.evict_tag) << 14) | (32'(idx) << 4) | (32'(i) << 2);
        a.wdata = bus.evict_line[i*32 +: 32];
        exp_q.push_back(a);
      end
    end
    for (int i = 0; i < 4; i++) begin
      w       = (start + i) % 4;
      a.we    = 1'b0;
      a.addr  = (32'(tag) << 14) | (32'(idx) << 4) | (32'(w) << 2);
      a.wdata = 32'd0;
      exp_q.push_back(a);
      exp_line[w*32 +: 32] = ram_base + 32'(w);
    end
    exp_index   = idx;
    accept_edge = cyc + 1;
    exp_commit  = accept_edge + 1 + exp_q.size() * (wait_cycles + 1);
    accept_gap  = cyc - last_done_neg;
    fill_active = 1'b1;
    rd_acks     = 0;
    wait_cnt    = 0;
  endtask

  // Per-cycle compare against the model, plus RAM ack/data generation
  task automatic monitor();
    acc_t        e;
    logic [31:0] d;
    bit          commit_exp;
    if (reset) begin
      exp_q.delete();
      fill_active = 1'b0;
      wait_cnt    = 0;
      crit_cyc    = -1;
      bus.mem_ack = 1'b0;
      chk("wren_in_reset", bus.cache_wrEn, 1'b0);
      return;
    end
    chk("fill_ready", bus.fill_ready, !fill_active);
    if (bus.fill_req && bus.fill_ready) begin
      plan_fill();
      accept_count++;
    end
    chk("mem_req", bus.mem_req, fill_active && (cyc > accept_edge) && (exp_q.size() > 0));
    chk("crit_valid", bus.crit_valid, cyc == crit_cyc);
    chk("crit_word", bus.crit_word, (cyc == crit_cyc) ? crit_exp : 32'd0);
    if (bus.crit_valid) got_crit = bus.crit_word;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'hDEAD_BEEF;
    if (bus.mem_req && exp_q.size() > 0) begin
      e = exp_q[0];
      chk("mem_we", bus.mem_we, e.we);
      chk("mem_addr", bus.mem_addr, e.addr);
      chk("mem_wdata", bus.mem_wdata, e.wdata);
      if (wait_cnt >= wait_cycles) begin
        wait_cnt    = 0;
        bus.mem_ack = 1'b1;
        addr_log.push_back(bus.mem_addr);
        wdata_log.push_back(bus.mem_wdata);
        if (!e.we) begin
          d             = ram_base + 32'(e.addr[3:2]);
          bus.mem_rdata = d;
          if (CRIT && rd_acks == 0) begin
            crit_cyc = cyc + 1;
            crit_exp = d;
          end
          rd_acks++;
        end
        void'(exp_q.pop_front());
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      chk("mem_wdata_idle", bus.mem_wdata, 32'd0);
    end
    commit_exp = fill_active && (exp_q.size() == 0) && (cyc == exp_commit);
    chk("cache_wrEn", bus.cache_wrEn, commit_exp);
    chk("fill_done", bus.fill_done, commit_exp);
    if (commit_exp) begin
      chk("cache_index", bus.cache_index, exp_index);
      chk("cache_line", bus.cache_line, exp_line);
      got_line      = bus.cache_line;
      commit_edge   = cyc;
      fill_active   = 1'b0;
      done_count++;
      last_done_neg = cyc;
    end else begin
      chk("cache_index_idle", bus.cache_index, 10'd0);
      chk("cache_line_idle", bus.cache_line, 128'd0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic launch(input logic [31:0] addr, input logic dirty, input logic [17:0] etag,
                        input logic [127:0] eline, input logic [31:0] base, input int waitc,
                        input bit hold);
    int start;
    int n;
    start           = accept_count;
    n               = 0;
    ram_base        = base;
    wait_cycles     = waitc;
    bus.fill_addr   = addr;
    bus.evict_dirty = dirty;
    bus.evict_tag   = etag;
    bus.evict_line  = eline;
    bus.fill_req    = 1'b1;
    addr_log.delete();
    wdata_log.delete();
    while (accept_count == start && n < 100) begin
      tick();
      n++;
    end
    chk("accept", accept_count - start, 1);
    if (!hold) bus.fill_req = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_count < target && n < 200) begin
      tick();
      n++;
    end
    chk("done_count", done_count, target);
  endtask

  initial begin
    logic [31:0] exp_a[4];
    int          start_acc;
    int          n;
    reset           = 1'b1;
    bus.fill_req    = 1'b0;
    bus.fill_addr   = 32'd0;
    bus.evict_dirty = 1'b0;
    bus.evict_tag   = 18'd0;
    bus.evict_line  = 128'd0;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = 32'd0;
    #1;
    chk("rst_fill_ready", bus.fill_ready, 1'b1);
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_cache_wrEn", bus.cache_wrEn, 1'b0);
    chk("rst_fill_done", bus.fill_done, 1'b0);
    chk("rst_cache_line", bus.cache_line, 128'd0);
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b0;

    // Clean fill, zero-wait RAM
    launch(32'h0001_2340, 1'b0, 18'd0, 128'd0, 32'hA0, 0, 1'b0);
    wait_done(1);
    chk("clean_latency", commit_edge - accept_edge, 5);
    exp_a = '{32'h12340, 32'h12344, 32'h12348, 32'h1234C};
    for (int i = 0; i < 4; i++) chk("clean_addr_seq", addr_log[i], exp_a[i]);
    chk("clean_line_lit", got_line, 128'h000000A3_000000A2_000000A1_000000A0);

    // Dirty fill: write-back then read
    launch(32'h0001_2340, 1'b1, 18'h3, 128'h00000044_00000033_00000022_00000011, 32'h50, 0, 1'b0);
    wait_done(2);
    chk("dirty_latency", commit_edge - accept_edge, 9);
    chk("dirty_wb0_addr", addr_log[0], 32'h0000_E340);
    chk("dirty_wb0_data", wdata_log[0], 32'h11);
    chk("dirty_wb3_addr", addr_log[3], 32'h0000_E34C);
    chk("dirty_wb3_data", wdata_log[3], 32'h44);
    chk("dirty_rd0_addr", addr_log[4], 32'h0001_2340);

    // Wait states: ack on every third request cycle
    launch(32'h0001_2340, 1'b0, 18'd0, 128'd0, 32'hA0, 2, 1'b0);
    wait_done(3);
    chk("wait_latency", commit_edge - accept_edge, 13);
    chk("wait_line_lit", got_line, 128'h000000A3_000000A2_000000A1_000000A0);

    // fill_req held high across a busy fill
    start_acc = accept_count;
    launch(32'h0003_5670, 1'b0, 18'd0, 128'd0, 32'h60, 0, 1'b1);
    bus.fill_addr   = 32'h0007_89A0;
    bus.evict_dirty = 1'b1;
    bus.evict_tag   = 18'h2A;
    bus.evict_line  = 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A;
    n = 0;
    while (accept_count < start_acc + 2 && n < 100) begin
      tick();
      n++;
    end
    chk("held_accepts", accept_count - start_acc, 2);
    chk("held_accept_gap", accept_gap, 1);
    bus.fill_req = 1'b0;
    wait_done(5);
    for (int i = 0; i < 5; i++) tick();
    chk("held_one_fill_each", accept_count - start_acc, 2);
    chk("held_done_total", done_count, 5);

    // Reset in RD after two acks, then a clean fill
    launch(32'h0001_2340, 1'b0, 18'd0, 128'd0, 32'h70, 0, 1'b0);
    n = 0;
    while (rd_acks < 2 && n < 50) begin
      tick();
      n++;
    end
    chk("rst_two_acks", rd_acks, 2);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_mem_req", bus.mem_req, 1'b0);
    chk("async_rst_ready", bus.fill_ready, 1'b1);
    chk("async_rst_wrEn", bus.cache_wrEn, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("rst_no_commit", done_count, 5);
    launch(32'h0002_4680, 1'b0, 18'd0, 128'd0, 32'hB0, 0, 1'b0);
    wait_done(6);
    chk("post_rst_line_lit", got_line, 128'h000000B3_000000B2_000000B1_000000B0);

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    // Critical word first from word offset 2
    launch(32'h0001_2348, 1'b0, 18'd0, 128'd0, 32'hA0, 0, 1'b0);
    wait_done(7);
    exp_a = '{32'h12348, 32'h1234C, 32'h12340, 32'h12344};
    for (int i = 0; i < 4; i++) chk("crit_addr_seq", addr_log[i], exp_a[i]);
    chk("crit_word_lit", got_crit, 32'hA2);
    chk("crit_line_lit", got_line, 128'h000000A3_000000A2_000000A1_000000A0);
`endif

    for (int i = 0; i < 3; i++) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
